// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester ports plus the SRAM side.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic                  req0;
  logic                  we0;
  logic [SW-1:0]         strb0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [SW-1:0]         strb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  lock1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  mem_en;
  logic                  mem_we;
  logic [SW-1:0]         mem_strb;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, we0, strb0, addr0, wdata0,
    input  req1, we1, strb1, addr1, wdata1, lock1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_en, mem_we, mem_strb, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, strb0, addr0, wdata0,
    output req1, we1, strb1, addr1, wdata1, lock1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_en, mem_we, mem_strb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-port data SRAM,
// with a host burst lock bounded by a grant counter.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 64
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(LOCK_MAX + 1);

  localparam logic [0:0] ARB       = 1'b0;
  localparam logic [0:0] HOST_LOCK = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_port_q, rsp_port_d;

  logic          gnt0;
  logic          gnt1;
  logic          locked;
  logic [CW-1:0] lock_inc;

  logic                  win_we;
  logic [SW-1:0]         win_strb;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  assign locked   = (state_q == HOST_LOCK) && bus.lock1;
  assign lock_inc = lock_cnt_q + 1'b1;

  // Dropping lock1 arbitrates normally in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (locked) begin
        gnt1 = bus.req1;
      end else if (bus.req0 && bus.req1) begin
        gnt0 = last_gnt_q;
        gnt1 = !last_gnt_q;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  always_comb begin
    win_we    = 1'b0;
    win_strb  = '0;
    win_addr  = '0;
    win_wdata = '0;
    unique case (1'b1)
      gnt0: begin
        win_we    = bus.we0;
        win_strb  = bus.strb0;
        win_addr  = bus.addr0;
        win_wdata = bus.wdata0;
      end
      gnt1: begin
        win_we    = bus.we1;
        win_strb  = bus.strb1;
        win_addr  = bus.addr1;
        win_wdata = bus.wdata1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_gnt_d = last_gnt_q;
    if (gnt0) last_gnt_d = 1'b0;
    if (gnt1) last_gnt_d = 1'b1;
    if (locked) begin
      if (gnt1) begin
        lock_cnt_d = lock_inc;
        if (lock_inc == CW'(LOCK_MAX)) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      end
    end else begin
      state_d    = ARB;
      lock_cnt_d = '0;
      // A single-grant lock expires on entry.
      if (gnt1 && bus.lock1 && (LOCK_MAX > 1)) begin
        state_d    = HOST_LOCK;
        lock_cnt_d = CW'(1);
      end
    end
  end

  assign rsp_valid_d = (gnt0 || gnt1) && !win_we;
  assign rsp_port_d  = gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      last_gnt_q  <= 1'b1;
      lock_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      lock_cnt_q  <= lock_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_en    = gnt0 || gnt1;
  assign bus.mem_we    = win_we;
  assign bus.mem_strb  = win_strb;
  assign bus.mem_addr  = win_addr;
  assign bus.mem_wdata = win_wdata;

  assign bus.rvalid0 = rsp_valid_q && !rsp_port_q;
  assign bus.rvalid1 = rsp_valid_q && rsp_port_q;
  assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level
// model of arbitration, locking and the SRAM contents.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LM = 4;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  dmem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LOCK_MAX(LM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] sram [NW];
  logic [DW-1:0] rd_q;
  logic          pl_en = 1'b0;
  logic [3:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      sram[pl_addr] <= pl_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_strb[b])
            sram[bus.mem_addr[3:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        rd_q <= sram[bus.mem_addr[3:0]];
      end
    end
  end
  assign bus.mem_rdata = rd_q;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ref_mem [NW];
  bit            m_locked;
  int            m_burst;
  bit            m_core_turn;
  bit            p_valid;
  bit            p_port;
  logic [DW-1:0] p_data;

  logic          o_gnt0, o_gnt1, o_rvalid0;
  logic [DW-1:0] o_rdata0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.strb0 = '0;
    bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.strb1 = '0;
    bus.addr1 = '0; bus.wdata1 = '0; bus.lock1 = 1'b0;
  endtask

  task automatic set0(bit we, logic [3:0] s, int a, logic [DW-1:0] d);
    bus.req0 = 1'b1; bus.we0 = we; bus.strb0 = s;
    bus.addr0 = AW'(a); bus.wdata0 = d;
  endtask

  task automatic set1(bit we, logic [3:0] s, int a,
                      logic [DW-1:0] d, bit lk);
    bus.req1 = 1'b1; bus.we1 = we; bus.strb1 = s;
    bus.addr1 = AW'(a); bus.wdata1 = d; bus.lock1 = lk;
  endtask

  task automatic model_reset();
    m_locked    = 1'b0;
    m_burst     = 0;
    m_core_turn = 1'b1;
    p_valid     = 1'b0;
    p_port      = 1'b0;
    p_data      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    @(negedge clk);
    chk("rst_gnt0",    64'(bus.gnt0),    64'(0));
    chk("rst_gnt1",    64'(bus.gnt1),    64'(0));
    chk("rst_mem_en",  64'(bus.mem_en),  64'(0));
    chk("rst_rvalid0", 64'(bus.rvalid0), 64'(0));
    chk("rst_rvalid1", 64'(bus.rvalid1), 64'(0));
    chk("rst_rdata0",  64'(bus.rdata0),  64'(0));
    chk("rst_maddr",   64'(bus.mem_addr), 64'(0));
    model_reset();
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One cycle: compare against the model, then advance the model.
  task automatic step();
    bit            e0, e1, ewe;
    logic [3:0]    es;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            xr0, xr1;
    @(negedge clk);
    if (m_locked && bus.lock1) begin
      e0 = 1'b0; e1 = bus.req1;
    end else if (bus.req0 && bus.req1) begin
      e0 = m_core_turn; e1 = !m_core_turn;
    end else begin
      e0 = bus.req0; e1 = bus.req1;
    end
    ewe = 1'b0; es = '0; ea = '0; ed = '0;
    if (e0) begin
      ewe = bus.we0; es = bus.strb0; ea = bus.addr0; ed = bus.wdata0;
    end else if (e1) begin
      ewe = bus.we1; es = bus.strb1; ea = bus.addr1; ed = bus.wdata1;
    end
    xr0 = p_valid && !p_port;
    xr1 = p_valid && p_port;
    chk("gnt0",      64'(bus.gnt0),      64'(e0));
    chk("gnt1",      64'(bus.gnt1),      64'(e1));
    chk("mem_en",    64'(bus.mem_en),    64'(e0 || e1));
    chk("mem_we",    64'(bus.mem_we),    64'(ewe));
    chk("mem_strb",  64'(bus.mem_strb),  64'(es));
    chk("mem_addr",  64'(bus.mem_addr),  64'(ea));
    chk("mem_wdata", 64'(bus.mem_wdata), 64'(ed));
    chk("rvalid0",   64'(bus.rvalid0),   64'(xr0));
    chk("rvalid1",   64'(bus.rvalid1),   64'(xr1));
    chk("rdata0",    64'(bus.rdata0),    64'(xr0 ? p_data : '0));
    chk("rdata1",    64'(bus.rdata1),    64'(xr1 ? p_data : '0));
    o_gnt0    = bus.gnt0;
    o_gnt1    = bus.gnt1;
    o_rvalid0 = bus.rvalid0;
    o_rdata0  = bus.rdata0;

    p_valid = (e0 || e1) && !ewe;
    p_port  = e1;
    p_data  = ref_mem[ea[3:0]];
    if ((e0 || e1) && ewe)
      for (int b = 0; b < 4; b++)
        if (es[b]) ref_mem[ea[3:0]][8*b +: 8] = ed[8*b +: 8];
    if (e0) m_core_turn = 1'b0;
    if (e1) m_core_turn = 1'b1;
    if (m_locked && bus.lock1) begin
      if (e1) begin
        m_burst++;
        if (m_burst >= LM) m_locked = 1'b0;
      end
    end else begin
      m_locked = 1'b0;
      if (e1 && bus.lock1) begin
        m_burst  = 1;
        m_locked = (m_burst < LM);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit       h0, h1;
    int       n0;
    logic [31:0] r;
    idle();
    rst = 1'b1;
    for (int i = 0; i < NW; i++) begin
      r = $urandom;
      if (i == 5) r = 32'hDEADBEEF;
      if (i == 7) r = 32'h01234567;
      pl_en = 1'b1; pl_addr = 4'(i); pl_data = r;
      ref_mem[i] = r;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;
    do_reset();

    set0(1'b0, 4'h0, 5, '0);
    step();
    chk("t1_gnt0", 64'(o_gnt0), 64'(1));
    idle();
    step();
    chk("t1_rvalid0", 64'(o_rvalid0), 64'(1));
    chk("t1_rdata0",  64'(o_rdata0),  64'(32'hDEADBEEF));

    do_reset();
    set0(1'b0, 4'h0, 1, '0);
    set1(1'b0, 4'h0, 2, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_gnt0", 64'(o_gnt0), 64'(k % 2 == 0));
    end
    idle();
    step();

    do_reset();
    set0(1'b0, 4'h0, 3, '0);
    step();
    for (int k = 0; k < 3; k++) begin
      set1(1'b1, 4'hF, k, 32'(8'h11 * (k + 1)), 1'b1);
      step();
      chk("t3_gnt1", 64'(o_gnt1), 64'(1));
    end
    bus.req1 = 1'b0;
    bus.lock1 = 1'b0;
    step();
    chk("t3_gnt0", 64'(o_gnt0), 64'(1));
    idle();
    step();

    do_reset();
    set0(1'b0, 4'h0, 4, '0);
    set1(1'b0, 4'h0, 6, '0, 1'b1);
    n0 = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (o_gnt0) n0++;
    end
    chk("t4_core_grants", 64'(n0), 64'(3));
    idle();
    step();

    do_reset();
    set0(1'b1, 4'b0010, 7, 32'hAABBCCDD);
    step();
    set0(1'b0, 4'h0, 7, '0);
    step();
    idle();
    step();
    chk("t5_rdata0", 64'(o_rdata0), 64'(32'h0123CC67));

    set0(1'b0, 4'h0, 5, '0);
    step();
    do_reset();
    step();
    chk("t6_rvalid0", 64'(o_rvalid0), 64'(0));
    set0(1'b0, 4'h0, 8, '0);
    set1(1'b0, 4'h0, 9, '0, 1'b0);
    step();
    chk("t6_gnt0", 64'(o_gnt0), 64'(1));
    idle();
    step();

    h0 = 1'b0;
    h1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!h0) begin
        if ($urandom_range(0, 2) != 0) begin
          h0 = 1'b1;
          r = $urandom;
          set0(r[0], r[7:4], $urandom_range(0, NW - 1), $urandom);
        end else bus.req0 = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        h0 = 1'b0;
        bus.req0 = 1'b0;
      end
      if (!h1) begin
        if ($urandom_range(0, 2) != 0) begin
          h1 = 1'b1;
          r = $urandom;
          set1(r[0], r[7:4], $urandom_range(0, NW - 1), $urandom,
               bus.lock1);
        end else bus.req1 = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        h1 = 1'b0;
        bus.req1 = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) bus.lock1 = !bus.lock1;
      step();
      if (o_gnt0) h0 = 1'b0;
      if (o_gnt1) h1 = 1'b0;
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
